// File: rtl/fetch_queue_frontend_if.sv
// Fetch front-end bus: flush controls, instruction-memory request/response and decode handshake.
// master = front end, slave = environment (memory, decode, branch unit).
interface fetch_queue_frontend_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned FQ_DEPTH = 4
);
  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

  logic            restart;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic [XLEN-1:0] imem_rsp_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic [CW-1:0]   fq_count;

  modport master (
    input  restart, redirect_valid, redirect_pc, imem_rsp_instr, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, fq_count
  );

  modport slave (
    output restart, redirect_valid, redirect_pc, imem_rsp_instr, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, fq_count
  );
endinterface

// File: rtl/fetch_queue_frontend.sv
// Instruction-fetch front end: PC generator with one-cycle-latency memory fetch feeding
// a credit-protected FIFO of {pc, instr} pairs; restart/redirect flush queue and in-flight fetch.
module fetch_queue_frontend #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     PC_STEP  = 1,
  parameter int unsigned     FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                    clk,
  input logic                    nrst,
  fetch_queue_frontend_if.master bus
);
  localparam int unsigned AW  = $clog2(FQ_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned CW1 = CW + 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] tag_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [XLEN-1:0] q_pc    [FQ_DEPTH];
  logic [XLEN-1:0] q_instr [FQ_DEPTH];

  logic flush_c;
  logic issue_c;
  logic push_c;
  logic pop_c;
  logic valid_c;

  // Credit counts the in-flight fetch so a response always has a free slot.
  always_comb begin
    flush_c = bus.restart | bus.redirect_valid;
    valid_c = (count != '0);
    issue_c = !flush_c && (({1'b0, count} + CW1'(inflight)) < CW1'(FQ_DEPTH));
    push_c  = inflight && !flush_c;
    pop_c   = valid_c && bus.out_ready;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc       <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= issue_c;
      if (issue_c) begin
        pc     <= pc + XLEN'(PC_STEP);
        tag_pc <= pc;
      end
      if (bus.restart) begin
        pc <= RESET_PC;
      end else if (bus.redirect_valid) begin
        pc <= bus.redirect_pc;
      end
      if (flush_c) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_c) wr_ptr <= wr_ptr + AW'(1);
        if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push_c) - CW'(pop_c);
      end
    end
  end

  // Queue storage; cleared on reset so the head reads 0 while held in reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (push_c) begin
      q_pc[wr_ptr]    <= tag_pc;
      q_instr[wr_ptr] <= bus.imem_rsp_instr;
    end
  end

  assign bus.imem_req_valid = issue_c & nrst;
  assign bus.imem_req_addr  = pc;
  assign bus.out_valid      = valid_c;
  assign bus.out_pc         = q_pc[rd_ptr];
  assign bus.out_instr      = q_instr[rd_ptr];
  assign bus.fq_count       = count;
endmodule
